// File: rtl/axis_depacketizer.sv
// rtl/axis_depacketizer.sv - fixed-length packet receiver: truncates long packets, flags short ones
// Forwards exactly the configured number of words per packet with a regenerated tlast.
module axis_depacketizer #(
   parameter int CNTR_WIDTH       = 32,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int STS_WIDTH        = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [CNTR_WIDTH-1:0]       cfg_data,
   output logic [STS_WIDTH-1:0]        sts_good,
   output logic [STS_WIDTH-1:0]        sts_short,
   output logic [STS_WIDTH-1:0]        sts_long,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic                        s_axis_tlast,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast
);

   typedef enum logic {PASS, DROP} state_t;

   state_t                      state_q, state_d;
   logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
   logic [CNTR_WIDTH-1:0]       len_q, len_d;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                        tvalid_q, tvalid_d;
   logic                        tlast_q, tlast_d;
   logic [STS_WIDTH-1:0]        good_q, good_d;
   logic [STS_WIDTH-1:0]        short_q, short_d;
   logic [STS_WIDTH-1:0]        long_q, long_d;

   logic                  s_ready;
   logic                  in_beat;
   logic                  first_beat;
   logic [CNTR_WIDTH-1:0] cur_len;
   logic [CNTR_WIDTH-1:0] word_idx;
   logic                  fwd;
   logic                  fwd_last;

   // The length in force is cfg_data on the first beat and the latched copy afterwards.
   assign s_ready    = (state_q == DROP) | ~tvalid_q | m_axis_tready;
   assign in_beat    = s_axis_tvalid & s_ready;
   assign first_beat = (cnt_q == '0);
   assign cur_len    = first_beat ? cfg_data : len_q;
   assign word_idx   = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      good_d   = good_q;
      short_d  = short_q;
      long_d   = long_q;
      fwd      = 1'b0;
      fwd_last = 1'b0;

      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end

      if (in_beat) begin
         case (state_q)
            PASS: begin
               if (first_beat) begin
                  len_d = cfg_data;
               end
               if (cur_len == '0) begin
                  long_d = long_q + 1'b1;
                  if (!s_axis_tlast) begin
                     state_d = DROP;
                  end
               end else if (word_idx == cur_len) begin
                  fwd      = 1'b1;
                  fwd_last = 1'b1;
                  cnt_d    = '0;
                  if (s_axis_tlast) begin
                     good_d = good_q + 1'b1;
                  end else begin
                     long_d  = long_q + 1'b1;
                     state_d = DROP;
                  end
               end else begin
                  fwd = 1'b1;
                  if (s_axis_tlast) begin
                     fwd_last = 1'b1;
                     short_d  = short_q + 1'b1;
                     cnt_d    = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            DROP: begin
               if (s_axis_tlast) begin
                  state_d = PASS;
               end
            end
            default: state_d = PASS;
         endcase
      end

      if (fwd) begin
         tdata_d  = s_axis_tdata;
         tlast_d  = fwd_last;
         tvalid_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= PASS;
         cnt_q    <= '0;
         len_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         good_q   <= '0;
         short_q  <= '0;
         long_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         good_q   <= good_d;
         short_q  <= short_d;
         long_q   <= long_d;
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign sts_good      = good_q;
   assign sts_short     = short_q;
   assign sts_long      = long_q;

endmodule

// File: tb/tb_axis_depacketizer.sv
// tb/tb_axis_depacketizer.sv - randomized bench for axis_depacketizer against a packet-level model
// Expected words are derived per whole packet from its length and the configured length.
module tb_axis_depacketizer;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] cfg_data;
   logic [31:0] sts_good, sts_short, sts_long;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast;

   axis_depacketizer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_data      (cfg_data),
      .sts_good      (sts_good),
      .sts_short     (sts_short),
      .sts_long      (sts_long),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_good = 0, exp_short = 0, exp_long = 0;
   int          ready_mode = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole-packet rule: P words against configured length L.
   task automatic model_pkt(input logic [31:0] base, input int p, input int l);
      int n_out;
      if (l == 0) begin
         exp_long++;
         return;
      end
      n_out = (p < l) ? p : l;
      for (int i = 0; i < n_out; i++) begin
         exp_q.push_back('{data: base + i, last: (i == n_out - 1)});
      end
      if (p == l) exp_good++;
      else if (p < l) exp_short++;
      else exp_long++;
   endtask

   always @(posedge aclk) begin
      #1;
      case (ready_mode)
         0: m_tready = 1'b1;
         1: m_tready = $urandom_range(0, 1) == 1;
         default: m_tready = 1'b0;
      endcase
   end

   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, prev_data);
            check("hold_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("out_data", m_tdata, e.data);
               check("out_last", m_tlast, e.last);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   task automatic send_pkt(input logic [31:0] base, input int len, input bit burst,
                           input int chg_idx, input logic [31:0] chg_cfg, input bit lat);
      model_pkt(base, len, int'(cfg_data));
      for (int i = 0; i < len; i++) begin
         int t;
         if (burst && $urandom_range(0, 2) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge aclk);
            #1;
         end
         if (i == chg_idx) cfg_data = chg_cfg;
         s_tvalid = 1'b1;
         s_tdata  = base + i;
         s_tlast  = (i == len - 1);
         t = 0;
         forever begin
            @(negedge aclk);
            if (s_tready) begin
               @(posedge aclk);
               #1;
               break;
            end
            @(posedge aclk);
            #1;
            t++;
            if (t > 1000) begin
               check("accept_timeout", 0, 1);
               break;
            end
         end
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         if (lat && i == 0) begin
            check("latency_valid", m_tvalid, 1);
            check("latency_data", m_tdata, base);
         end
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge aclk);
         t++;
      end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   task automatic check_sts(input string tag);
      check({tag, "_good"}, sts_good, exp_good);
      check({tag, "_short"}, sts_short, exp_short);
      check({tag, "_long"}, sts_long, exp_long);
   endtask

   initial begin
      aresetn  = 1'b0;
      cfg_data = 32'd4;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_valid", m_tvalid, 0);
      check("rst_last", m_tlast, 0);
      check("rst_data", m_tdata, 0);
      check_sts("rst");
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Exact-length packets with the one-cycle latency probe.
      send_pkt(32'h10, 4, 0, -1, 0, 1);
      send_pkt(32'h20, 4, 0, -1, 0, 0);
      drain();
      check_sts("good2");

      send_pkt(32'hA0, 2, 0, -1, 0, 0);
      drain();
      check_sts("short");

      cfg_data = 32'd3;
      send_pkt(32'hB0, 6, 0, -1, 0, 0);
      send_pkt(32'hC0, 3, 0, -1, 0, 0);
      drain();
      check_sts("long");

      // Zero configured length: multi-beat then single-beat packet.
      cfg_data = 32'd0;
      send_pkt(32'hD0, 2, 0, -1, 0, 0);
      send_pkt(32'hD8, 1, 0, -1, 0, 0);
      cfg_data = 32'd3;
      send_pkt(32'hE0, 3, 0, -1, 0, 0);
      drain();
      check_sts("zero_len");

      cfg_data   = 32'd4;
      ready_mode = 1;
      for (int p = 0; p < 100; p++) begin
         send_pkt(32'h1000 + p * 16, 4, 1, -1, 0, 0);
      end
      drain();
      check_sts("random");

      // Mixed random lengths under backpressure.
      for (int p = 0; p < 30; p++) begin
         cfg_data = $urandom_range(1, 5);
         send_pkt(32'h8000 + p * 16, $urandom_range(1, 7), 1, -1, 0, 0);
      end
      drain();
      check_sts("mixed");

      ready_mode = 0;
      @(posedge aclk);
      #1;
      cfg_data = 32'd4;
      send_pkt(32'h40, 4, 0, 1, 32'd2, 0);
      send_pkt(32'h48, 4, 0, -1, 0, 0);
      drain();
      check_sts("cfg_change");

      ready_mode = 2;
      @(posedge aclk);
      #1;
      cfg_data = 32'd4;
      s_tvalid = 1'b1;
      s_tdata  = 32'h50;
      s_tlast  = 1'b0;
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;
      check("pre_rst_valid", m_tvalid, 1);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      check("mid_rst_valid", m_tvalid, 0);
      exp_q.delete();
      exp_good  = 0;
      exp_short = 0;
      exp_long  = 0;
      check_sts("mid_rst");
      aresetn    = 1'b1;
      ready_mode = 0;
      @(posedge aclk);
      #1;
      send_pkt(32'h60, 4, 0, -1, 0, 0);
      drain();
      check_sts("post_rst");

      repeat (5) @(posedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
